// File: rtl/sipo_pkg.sv
// Shared constants for the serial-to-parallel word assembler: FSM encoding and default word width.
package sipo_pkg;
    localparam int SIPO_WIDTH = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;
endpackage

// File: rtl/sipo_ctrl_if.sv
// Serial input / parallel output bundle; master drives the serial side and consumes the word, slave is the assembler.
interface sipo_ctrl_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH
);
    logic             serial_in;
    logic             serial_valid;
    logic             sof;
    logic             out_ready;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             busy;
    logic             overrun;
    logic             frame_err;

    modport master (
        output serial_in, serial_valid, sof, out_ready,
        input  parallel_out, out_valid, busy, overrun, frame_err
    );

    modport slave (
        input  serial_in, serial_valid, sof, out_ready,
        output parallel_out, out_valid, busy, overrun, frame_err
    );
endinterface

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter; load restarts a frame with bit_in as bit 1, shift appends one bit.
// Zero latency: last is asserted combinationally in the cycle the WIDTH-th bit is shifted; no backpressure.
module sipo_shift_core #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             bit_in,
    output logic [WIDTH-1:0] sreg,
    output logic             last
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt;

    assign last = shift && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= MSB_FIRST ? {{(WIDTH-1){1'b0}}, bit_in} : {bit_in, {(WIDTH-1){1'b0}}};
            cnt  <= CW'(1);
        end else if (shift) begin
            sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], bit_in} : {bit_in, sreg[WIDTH-1:1]};
            cnt  <= last ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/sipo_ctrl.sv
// Frame FSM, one-word holding register and out_valid/out_ready handshake around sipo_shift_core.
// Word appears one cycle after the edge taking its last bit; a word completing into a stalled full holding register is dropped (overrun).
module sipo_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    sipo_ctrl_if.slave  bus
);
    if (WIDTH < 2) begin : g_bad_width
        $error("sipo_ctrl: WIDTH must be at least 2");
    end

    logic [0:0]       state;
    logic             pend;
    logic [WIDTH-1:0] sreg;
    logic             last;
    logic [WIDTH-1:0] hold_q;
    logic             hold_vld;
    logic             overrun_q;
    logic             frame_err_q;
    logic             start;
    logic             shift;

    // A sof bit always starts a frame, in IDLE or as an abort in SHIFT.
    assign start = bus.serial_valid && bus.sof;
    assign shift = bus.serial_valid && !bus.sof && (state == ST_SHIFT);

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start),
        .shift  (shift),
        .bit_in (bus.serial_in),
        .sreg   (sreg),
        .last   (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pend        <= 1'b0;
            hold_q      <= '0;
            hold_vld    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= start && (state == ST_SHIFT);
            overrun_q   <= 1'b0;
            pend        <= last;

            if (start) begin
                state <= ST_SHIFT;
            end else if (last) begin
                state <= ST_IDLE;
            end

            // sreg still holds the completed word during the pend cycle even if a new frame starts.
            if (pend) begin
                if (!hold_vld || bus.out_ready) begin
                    hold_q   <= sreg;
                    hold_vld <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (hold_vld && bus.out_ready) begin
                hold_vld <= 1'b0;
            end
        end
    end

    assign bus.parallel_out = hold_q;
    assign bus.out_valid    = hold_vld;
    assign bus.busy         = (state == ST_SHIFT);
    assign bus.overrun      = overrun_q;
    assign bus.frame_err    = frame_err_q;
endmodule

// File: tb/tb_sipo_ctrl.sv
// Directed bench: stimulus pushes expected words into queues, a negedge monitor pops them on each accepted word.
module tb_sipo_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sipo_ctrl_if #(.WIDTH(8)) bm ();
    sipo_ctrl_if #(.WIDTH(8)) bl ();

    sipo_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut   (.clk(clk), .rst_n(rst_n), .bus(bm));
    sipo_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bl));

    int checks   = 0;
    int errors   = 0;
    int ovr_cnt  = 0;
    int ferr_cnt = 0;
    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_dat  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pulse counting, stability under stall, scoreboard pop on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bm.overrun)   ovr_cnt++;
            if (bm.frame_err) ferr_cnt++;
            if (prev_hold && bm.out_valid) check("hold_stable", bm.parallel_out, prev_dat);
            if (bm.out_valid && bm.out_ready) begin
                if (q_m.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word_m: got %0h expected none", bm.parallel_out);
                end else begin
                    check("word_m", bm.parallel_out, q_m.pop_front());
                end
            end
            if (bl.out_valid && bl.out_ready) begin
                if (q_l.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word_l: got %0h expected none", bl.parallel_out);
                end else begin
                    check("word_l", bl.parallel_out, q_l.pop_front());
                end
            end
            prev_hold = bm.out_valid && !bm.out_ready;
            prev_dat  = bm.parallel_out;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Sends seq[7] first; sof on the first bit; gap idle cycles after each bit.
    task automatic send(input bit lsb, input logic [7:0] seq, input int nbits, input int gap, input bit toggle_rdy);
        for (int i = 0; i < nbits; i++) begin
            if (lsb) begin
                bl.serial_in    = seq[7-i];
                bl.serial_valid = 1'b1;
                bl.sof          = (i == 0);
            end else begin
                bm.serial_in    = seq[7-i];
                bm.serial_valid = 1'b1;
                bm.sof          = (i == 0);
            end
            @(posedge clk); #1;
            bm.serial_valid = 1'b0; bm.sof = 1'b0;
            bl.serial_valid = 1'b0; bl.sof = 1'b0;
            for (int g = 0; g < gap; g++) begin
                if (toggle_rdy) bm.out_ready = ~bm.out_ready;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},  bm.out_valid,    0);
        check({tag, "_pout"},   bm.parallel_out, 0);
        check({tag, "_busy"},   bm.busy,         0);
        check({tag, "_ovr"},    bm.overrun,      0);
        check({tag, "_ferr"},   bm.frame_err,    0);
    endtask

    initial begin
        bm.serial_in = 0; bm.serial_valid = 0; bm.sof = 0; bm.out_ready = 1;
        bl.serial_in = 0; bl.serial_valid = 0; bl.sof = 0; bl.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MSB first, 1 cycle completion latency, cleared next cycle.
        q_m.push_back(8'hA5);
        send(0, 8'hA5, 8, 0, 0);
        check("a5_pend_valid", bm.out_valid, 0);
        check("a5_busy_done",  bm.busy,      0);
        @(posedge clk); #1;
        check("a5_valid", bm.out_valid,    1);
        check("a5_pout",  bm.parallel_out, 8'hA5);
        @(posedge clk); #1;
        check("a5_cleared", bm.out_valid, 0);

        // LSB first.
        q_l.push_back(8'h03);
        send(1, 8'b1100_0000, 8, 0, 0);
        @(posedge clk); #1;
        check("lsb_valid", bl.out_valid,    1);
        check("lsb_pout",  bl.parallel_out, 8'h03);
        repeat (2) @(posedge clk);
        #1;

        // Overrun: second frame dropped while stalled.
        bm.out_ready = 1'b0;
        q_m.push_back(8'h3C);
        send(0, 8'h3C, 8, 0, 0);
        send(0, 8'hC3, 8, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("ovr_pout",  bm.parallel_out, 8'h3C);
        check("ovr_valid", bm.out_valid,    1);
        check("ovr_count", ovr_cnt,         1);
        bm.out_ready = 1'b1;
        @(posedge clk); #1;
        check("ovr_drain", bm.out_valid, 0);

        // Frame abort after 4 bits.
        q_m.push_back(8'h81);
        send(0, 8'hA0, 4, 0, 0);
        check("abort_busy", bm.busy, 1);
        send(0, 8'h81, 8, 0, 0);
        @(posedge clk); #1;
        check("abort_pout", bm.parallel_out, 8'h81);
        @(posedge clk); #1;
        check("ferr_count", ferr_cnt, 1);

        // Reset mid-frame.
        send(0, 8'hFF, 5, 0, 0);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset with a word held.
        bm.out_ready = 1'b0;
        send(0, 8'hFF, 8, 0, 0);
        @(posedge clk); #1;
        check("rst_hold_valid", bm.out_valid,    1);
        check("rst_hold_pout",  bm.parallel_out, 8'hFF);
        rst_n = 1'b0;
        #1;
        check_zero("rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bm.out_ready = 1'b1;
        q_m.push_back(8'h5A);
        send(0, 8'h5A, 8, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovr_count",  ovr_cnt,  1);
        check("rst_ferr_count", ferr_cnt, 1);

        // Gapped input with toggling out_ready.
        q_m.push_back(8'hF0);
        send(0, 8'hF0, 8, 2, 1);
        bm.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bm.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int t = 0; t < 50 && (q_m.size() != 0 || q_l.size() != 0); t++) begin
            @(posedge clk); #1;
        end
        check("queue_drained", q_m.size() + q_l.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sipo_ctrl.md
SIPO_CTRL -- requirements
Module: sipo_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of serial bits per word (2..32).
REQ-002 SHALL provide parameter MSB_FIRST, default 1; 1 means the first received bit lands in parallel_out[WIDTH-1], 0 means it lands in bit 0.
REQ-003 SHALL provide port clk  input  1  sole clock, rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port serial_in  input  1  serial data bit.
REQ-006 SHALL provide port serial_valid  input  1  qualifies serial_in for one clk cycle.
REQ-007 SHALL provide port sof  input  1  start-of-frame, coincident with the first bit; ignored unless serial_valid=1.
REQ-008 SHALL provide port out_ready  input  1  consumer accepts parallel_out.
REQ-009 SHALL provide port parallel_out  output  WIDTH  assembled word.
REQ-010 SHALL provide port out_valid  output  1  parallel_out holds an unconsumed word.
REQ-011 SHALL provide port busy  output  1  a frame is being shifted in (state SHIFT).
REQ-012 SHALL provide port overrun  output  1  one-cycle pulse: a completed word was dropped.
REQ-013 SHALL provide port frame_err  output  1  one-cycle pulse: a frame was aborted by a new sof.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT, plus a WIDTH-bit shift register, a bit counter of $clog2(WIDTH+1) bits and an output holding register with its valid flag.
REQ-015 IDLE->SHIFT SHALL occur on serial_valid&&sof; that bit is stored as bit 1 and the counter is set to 1.
REQ-016 In IDLE, serial_valid without sof SHALL be discarded with no other effect.
REQ-017 In SHIFT, each serial_valid bit SHALL be shifted in per MSB_FIRST and the counter incremented; cycles with serial_valid=0 SHALL hold all state.
REQ-018 The WIDTH-th accepted bit SHALL complete the word; the FSM returns to IDLE on that edge and the counter clears.
REQ-019 On completion, the word SHALL appear on parallel_out with out_valid=1 on the next rising edge (latency 1 cycle after the last bit's edge), provided the holding register is free.
REQ-020 The holding register is free when out_valid=0, or when out_valid&&out_ready in the completion cycle; in that case the new word is loaded and out_valid stays 1 with no bubble.
REQ-021 If a word completes while out_valid=1 and out_ready=0, the new word SHALL be dropped, parallel_out SHALL stay unchanged, and overrun SHALL pulse on the next edge.
REQ-022 out_valid&&out_ready with no completing word SHALL clear out_valid on the next edge; parallel_out keeps its last value.
REQ-023 parallel_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 In SHIFT, serial_valid&&sof SHALL abort the partial frame, pulse frame_err on the next edge, and restart the frame with this bit as bit 1 (state stays SHIFT).
REQ-025 A frame of WIDTH=1 is illegal; WIDTH<2 SHALL be rejected at elaboration.
REQ-026 busy SHALL equal (state==SHIFT); all outputs SHALL be registered.
REQ-027 Shifting into the shift register SHALL continue while out_valid=1 (one word of buffering).

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, counter=0, shift register=0, parallel_out=0, out_valid=0, overrun=0, frame_err=0.
REQ-029 Reset asserted mid-frame or with out_valid=1 SHALL discard all data without raising overrun or frame_err.
REQ-030 After rst_n deasserts, the first serial_valid&&sof edge SHALL start a frame normally.

Structure
REQ-031 State encoding (IDLE, SHIFT) SHALL be defined in a shared package sipo_pkg together with the default WIDTH constant.
REQ-032 The shift register plus bit counter SHALL be one sub-module, sipo_shift_core; the FSM, holding register and handshake logic live in sipo_ctrl.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1, out_ready=1: bits 1,0,1,0,0,1,0,1 (sof on the first) -> parallel_out=8'hA5 with out_valid=1 one cycle after the 8th bit, cleared the following cycle.
REQ-034 MSB_FIRST=0, same bits -> parallel_out=8'hA5 bit-reversed = 8'hA5 is a palindrome, so use bits 1,1,0,0,0,0,0,0 instead -> parallel_out=8'h03.
REQ-035 out_ready=0, two back-to-back frames 8'h3C then 8'hC3 -> parallel_out stays 8'h3C and overrun pulses once; after out_ready=1, out_valid falls.
REQ-036 sof re-asserted after 4 bits, then 8 bits of 8'h81 -> frame_err pulses once and parallel_out=8'h81.
REQ-037 rst_n pulsed low after 5 bits and again while out_valid=1 -> all outputs 0 immediately, no overrun/frame_err; the next frame 8'h5A is received correctly.
REQ-038 serial_valid gapped (1 cycle on, 2 off) across a frame 8'hF0 with out_ready toggling -> word correct, parallel_out stable while out_valid=1 and out_ready=0.
